// File: rtl/lsu_mem_access.sv
// lsu_mem_access: load/store unit for the NPC memory stage.
// Takes one request at a time from the pipeline over a valid/ready handshake.
// It checks the size and alignment of the request and then drives a
// request/acknowledge memory bus with byte-lane steering.
// Load data is extracted from the lane and sign- or zero-extended.
// A memory access that does not get an ack in time ends with an error response.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_wen, req_addr, req_wdata  store flag, byte address, right-justified store data
//   req_size, req_unsigned        log2 access bytes, zero-extend loads when 1
//   resp_valid/resp_ready         response handshake
//   resp_rdata, resp_err          extended load data (0 for stores/errors), error flag
//   mem_ren, mem_wen              memory read/write strobes, held until ack/timeout
//   mem_addr, mem_wdata, mem_wmask  bus-aligned address, lane-shifted data, byte enables
//   mem_rdata, mem_ack            read data (valid with ack), access complete
module lsu_mem_access #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int CW  = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_reg;
  logic [CW-1:0]   tmo_cnt_reg;
  logic            wen_reg;
  logic [1:0]      size_reg;
  logic [OFF-1:0]  off_reg;
  logic            unsigned_reg;

  // Request decode, evaluated on the incoming request in IDLE
  logic [OFF-1:0]  req_off;
  logic            req_illegal;
  logic            req_misaligned;
  logic [NB-1:0]   req_mask;

  always_comb begin
    req_off        = req_addr[OFF-1:0];
    req_illegal    = (req_size == 2'd3) && (DATA_WIDTH != 64);
    req_misaligned = 1'b0;
    // Misaligned when any of the low 'size' address bits is set
    for (int i = 0; i < OFF; i++) begin
      if (i < int'(req_size) && req_addr[i]) req_misaligned = 1'b1;
    end
    req_mask = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < (1 << req_size)) req_mask[i] = 1'b1;
    end
    req_mask = req_mask << req_off;
  end

  // Load extraction from the latched offset/size; captured only on ack
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] rd_ext;
  logic                  rd_sign;

  always_comb begin
    rd_shift = mem_rdata >> {off_reg, 3'b000};
    case (size_reg)
      2'd0:    rd_sign = rd_shift[7];
      2'd1:    rd_sign = rd_shift[15];
      2'd2:    rd_sign = rd_shift[31];
      default: rd_sign = rd_shift[DATA_WIDTH-1];
    endcase
    rd_ext = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < (8 << size_reg)) rd_ext[i] = rd_shift[i];
      else                     rd_ext[i] = rd_sign & ~unsigned_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      tmo_cnt_reg  <= '0;
      wen_reg      <= 1'b0;
      size_reg     <= '0;
      off_reg      <= '0;
      unsigned_reg <= 1'b0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      mem_ren      <= 1'b0;
      mem_wen      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            wen_reg      <= req_wen;
            size_reg     <= req_size;
            off_reg      <= req_off;
            unsigned_reg <= req_unsigned;
            tmo_cnt_reg  <= '0;
            req_ready    <= 1'b0;
            if (req_illegal || req_misaligned) begin
              // Rejected without touching the bus
              state_reg  <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state_reg <= ACCESS;
              mem_ren   <= ~req_wen;
              mem_wen   <= req_wen;
              mem_addr  <= {req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
              mem_wdata <= req_wdata << {req_off, 3'b000};
              mem_wmask <= req_mask;
            end
          end
        end
        ACCESS: begin
          // Ack takes priority over an expiring timeout in the same cycle
          if (mem_ack || tmo_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
            state_reg  <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= ~mem_ack;
            resp_rdata <= (mem_ack && !wen_reg) ? rd_ext : '0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_reg  <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Testbench for lsu_mem_access (DATA_WIDTH = 32, TIMEOUT_CYCLES = 4).
// It runs directed cases first and then randomized transactions.
// Expected responses come from a byte-level reference model.
module tb_lsu_mem_access;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wen = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    req_size = '0;
  logic          req_unsigned = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          mem_ren;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_mem_access #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction: ack_at = ACCESS cycle index of the ack (-1 = never),
  // hold = cycles resp_ready is kept low once the response is up.
  task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns, input int ack_at,
                     input logic [31:0] rword, input int hold);
    int nbytes;
    int off;
    bit bad;
    bit acked;
    int strobes;
    longint unsigned lanes;
    longint unsigned vmask;
    longint unsigned val;
    logic [31:0] exp_rdata;
    logic [31:0] snap;
    nbytes  = 1 << size;
    off     = int'(addr % 4);
    bad     = (size == 2'd3) || (addr % nbytes != 0);
    acked   = !bad && ack_at >= 0 && ack_at < TMO;
    strobes = 0;
    lanes   = ((64'd1 << nbytes) - 1) << off;

    chk("req_ready_idle", 64'(req_ready), 64'd1);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    tick;
    // Scramble request inputs so any missing latch shows up
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_wen = 1'($urandom); req_unsigned = 1'($urandom);

    if (!bad) begin
      for (int c = 0; c < TMO; c++) begin
        chk("strobe", 64'({mem_ren, mem_wen}), wen ? 64'd1 : 64'd2);
        chk("mem_addr", 64'(mem_addr), 64'(addr & 32'hFFFF_FFFC));
        chk("mem_wmask", 64'(mem_wmask), lanes);
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        if (wen) begin
          for (int l = 0; l < 4; l++) begin
            if (lanes[l]) chk("mem_wdata_lane", 64'(mem_wdata[8*l +: 8]), 64'(wdata[8*(l-off) +: 8]));
          end
        end
        strobes++;
        if (c == ack_at) begin
          mem_ack = 1'b1; mem_rdata = rword;
          tick;
          mem_ack = 1'b0; mem_rdata = $urandom;
          break;
        end
        tick;
      end
    end

    exp_rdata = '0;
    if (acked && !wen) begin
      vmask = (64'd1 << (8 * nbytes)) - 1;
      val   = (64'(rword) >> (8 * off)) & vmask;
      if (!uns && val[8*nbytes-1]) val = val | ~vmask;
      exp_rdata = val[31:0];
    end

    chk("strobe_cycles", 64'(strobes), bad ? 64'd0 : (acked ? 64'(ack_at + 1) : 64'(TMO)));
    chk("resp_valid", 64'(resp_valid), 64'd1);
    chk("resp_err", 64'(resp_err), 64'(!acked));
    chk("resp_rdata", 64'(resp_rdata), 64'(exp_rdata));
    chk("strobe_in_resp", 64'({mem_ren, mem_wen}), 64'd0);
    snap = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      tick;
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", 64'(resp_rdata), 64'(snap));
      chk("hold_err", 64'(resp_err), 64'(!acked));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("post_resp_valid", 64'(resp_valid), 64'd0);
    chk("post_req_ready", 64'(req_ready), 64'd1);
    $display("txn wen=%0d addr=%h size=%0d uns=%0d ack_at=%0d -> err=%0d rdata=%h",
             wen, addr, size, uns, ack_at, !acked, exp_rdata);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    int          d;
    rst = 1'b1;
    tick;
    tick;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_strobes", 64'({mem_ren, mem_wen}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    rst = 1'b0;
    tick;

    // Directed cases
    txn(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0, 2, 32'h0, 0);
    txn(1'b1, 32'h8000_0003, 32'h0000_00A5, 2'd0, 1'b0, 1, 32'h0, 0);
    txn(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 0, 32'h8001_1234, 0);
    txn(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 0, 32'h8001_1234, 1);
    txn(1'b0, 32'h8000_0006, 32'h0, 2'd2, 1'b0, 0, 32'h0, 0);
    txn(1'b0, 32'h8000_0000, 32'h0, 2'd3, 1'b0, 0, 32'h0, 0);
    txn(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0, -1, 32'h0, 0);
    txn(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0, 3, 32'h1234_5678, 0);
    txn(1'b0, 32'h8000_0001, 32'h0, 2'd0, 1'b0, 1, 32'h0000_F000, 5);

    // Stray ack while idle must be ignored
    mem_ack = 1'b1;
    tick;
    tick;
    mem_ack = 1'b0;
    chk("idle_ack_resp_valid", 64'(resp_valid), 64'd0);
    chk("idle_ack_req_ready", 64'(req_ready), 64'd1);
    chk("idle_ack_strobes", 64'({mem_ren, mem_wen}), 64'd0);

    // Reset during ACCESS drops the transaction
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0008; req_size = 2'd2;
    tick;
    req_valid = 1'b0;
    chk("rst_mid_ren", 64'(mem_ren), 64'd1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_mid_strobes", 64'({mem_ren, mem_wen}), 64'd0);
    chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
    tick;
    tick;
    chk("rst_mid_no_resp", 64'(resp_valid), 64'd0);
    $display("txn reset during ACCESS -> dropped");

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      s = 2'($urandom_range(0, 3));
      a = 32'h8000_0000 | ($urandom & 32'h0000_00FF);
      if (s != 2'd3 && $urandom_range(0, 2) != 0) a = a & ~((32'd1 << s) - 1);
      d = $urandom_range(0, 5);
      if (d >= TMO) d = -1;
      txn(1'($urandom), a, $urandom, s, 1'($urandom), d, $urandom, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Parametrised load/store unit for the NPC memory stage.
- Accepts one load or store request at a time from the pipeline over a valid/ready handshake and generates byte-lane-aligned accesses on a request/acknowledge memory bus.
- Performs alignment checks, store lane steering, load extraction with sign or zero extension, and timeout detection.
- Returns each result over a valid/ready response handshake.

Parameters:
- ADDR_WIDTH, 32: width of request and memory addresses.
- DATA_WIDTH, 32: bus data width; legal values are 32 and 64. OFF = log2(DATA_WIDTH/8).
- TIMEOUT_CYCLES, 255: number of ACCESS cycles without mem_ack before an error response is returned; must be at least 1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_WIDTH = 64).
- req_unsigned  in  1  load uses zero extension when 1, sign extension when 0.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accepted.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and for errors.
- resp_err  out  1  misaligned access, illegal size, or timeout.
- mem_ren  out  1  memory read strobe.
- mem_wen  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  req_addr with its low OFF bits cleared.
- mem_wdata  out  DATA_WIDTH  req_wdata shifted left by 8*offset.
- mem_wmask  out  DATA_WIDTH/8  byte-enable mask.
- mem_rdata  in  DATA_WIDTH  read data; valid only in the cycle mem_ack is high.
- mem_ack  in  1  memory access complete.

Behaviour:
- States are IDLE, ACCESS and RESP. The reset state is IDLE.
- Reset values: every output is 0 except req_ready, which is 1. The timeout counter and all latched fields are cleared.
- IDLE:
  - req_ready = 1 and nothing else is asserted.
  - On req_valid & req_ready, latch wen, addr, wdata, size and unsigned.
  - A request is misaligned when addr mod 2^size != 0.
  - An illegal or misaligned request goes to RESP with err = 1 and rdata = 0. No memory strobe is raised.
  - Any other request goes to ACCESS.
- ACCESS:
  - Exactly one of mem_ren or mem_wen is held high every cycle until the state exits.
  - mem_addr, mem_wdata and mem_wmask are stable for the whole state.
  - offset = addr[OFF-1:0].
  - mem_wmask = ((1 << 2^size) - 1) << offset for both loads and stores. Lanes outside the mask are don't-care on mem_wdata.
- On mem_ack:
  - Loads: take mem_rdata >> (8*offset) and truncate it to 8·2^size bits. Sign- or zero-extend the result to DATA_WIDTH. Capture it into resp_rdata.
  - Stores: resp_rdata = 0.
  - Go to RESP with err = 0. Strobes drop in the next cycle.
- Timeout:
  - The counter starts at 0 on entry to ACCESS and increments every ACCESS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES - 1 with no ack, go to RESP with err = 1 and rdata = 0.
  - If ack and the timeout condition occur in the same cycle, ack wins.
- RESP:
  - resp_valid = 1, with resp_rdata and resp_err stable, until resp_ready is sampled high. Then go to IDLE.
  - resp_ready may already be high on the first RESP cycle.
- Throughput and latency:
  - req_ready is high only in IDLE, so there is one outstanding request at most.
  - With mem_ack arriving N cycles after ACCESS entry (N ≥ 0) and resp_ready tied high, the response is visible N+2 cycles after request acceptance.
  - The next request can be accepted the cycle after the response handshake.
- mem_ack in IDLE or RESP is ignored.
- Reset mid-transaction: the transaction is dropped and no response is produced. Strobes are low from the cycle after rst is sampled high.

Test Plan:
- DATA_WIDTH = 32, store word: addr 0x8000_0004, wdata 0xDEAD_BEEF, ack after 2 cycles → mem_addr 0x8000_0004, mem_wmask 1111, mem_wen high for exactly 3 cycles, resp err = 0, rdata = 0.
- Store byte: addr 0x8000_0003, wdata 0x0000_00A5 → mem_addr 0x8000_0000, mem_wmask 1000, mem_wdata[31:24] = 0xA5.
- Signed load half: addr 0x8000_0002, mem_rdata 0x8001_1234 → resp_rdata 0xFFFF_8001. Repeat with req_unsigned = 1 → 0x0000_8001.
- Misaligned word load at 0x8000_0006 → no mem_ren at any time, resp_err = 1 one cycle after acceptance. size = 3 with DATA_WIDTH = 32 → the same response.
- Timeout: TIMEOUT_CYCLES = 4, mem_ack never asserted → mem_ren high for exactly 4 cycles, then resp_err = 1. A second run with ack in the 4th cycle → err = 0.
- Backpressure and reset: hold resp_ready low for 5 cycles → resp_valid and resp_rdata stable and req_ready low throughout. A separate run asserting rst during ACCESS → strobes 0 the next cycle, no resp_valid, req_ready = 1.
